// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM state encoding and
// default frame timing, used by both the receive and transmit sides.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

  // 50 MHz / 38_400 baud
  localparam int DEF_CLKS_PER_BIT = 1302;
  // 8N1: start + 8 data + stop
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is chosen to match the input's idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with mid-bit sampling, a held
// data register with ready/ack handshake, and error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RxIn,
  input  logic                 RxAck,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxReady,
  output logic                 FrameError,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

  localparam logic [2:0] IDLE      = RX_IDLE;
  localparam logic [2:0] START     = RX_START;
  localparam logic [2:0] DATA      = RX_DATA;
  localparam logic [2:0] STOP      = RX_STOP;
  localparam logic [2:0] WAIT_HIGH = RX_WAIT_HIGH;

  logic                 rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] sh;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (Clock),
    .rst_n(Reset),
    .d    (RxIn),
    .q    (rx_s)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      RxData     <= '0;
      RxReady    <= 1'b0;
      FrameError <= 1'b0;
      Overrun    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      FrameError <= 1'b0;
      Overrun    <= 1'b0;
      if (RxAck) RxReady <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            Busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            sh  <= {rx_s, sh[DATA_BITS-1:1]};
            idx <= idx + 3'd1;
            if (idx == LAST) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (rx_s) begin
              // ack on the load cycle keeps the new byte ready
              RxData  <= sh;
              RxReady <= 1'b1;
              Overrun <= RxReady && !RxAck;
              state   <= IDLE;
              Busy    <= 1'b0;
            end else begin
              FrameError <= 1'b1;
              state      <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes,
// a negedge monitor pops and compares on each new-byte event.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          RxIn  = 1'b1;
  logic          RxAck = 1'b0;
  logic [DB-1:0] RxData;
  logic          RxReady;
  logic          FrameError;
  logic          Overrun;
  logic          Busy;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .RxIn      (RxIn),
    .RxAck     (RxAck),
    .RxData    (RxData),
    .RxReady   (RxReady),
    .FrameError(FrameError),
    .Overrun   (Overrun),
    .Busy      (Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] d;
    logic       ov;
  } exp_t;

  exp_t q[$];

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int ov_cnt  = 0;
  int fe_cnt  = 0;
  int rdy_evt = 0;

  logic       prev_rdy  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (Overrun) ov_cnt++;
    if (FrameError) fe_cnt++;
    if (Reset && RxReady &&
        (!prev_rdy || RxData !== prev_data)) begin
      rdy_evt++;
      if (q.size() == 0) begin
        check("unexpected_byte", {24'h0, RxData}, 32'hdead);
      end else begin
        e = q.pop_front();
        check("rx_data", {24'h0, RxData}, {24'h0, e.d});
        check("overrun_at_load", {31'h0, Overrun}, {31'h0, e.ov});
      end
    end
    prev_rdy  = RxReady;
    prev_data = RxData;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RxIn = f[i];
      repeat (CPB) @(posedge Clock);
      #1;
    end
  endtask

  task automatic ack();
    RxAck = 1'b1;
    @(posedge Clock);
    #1;
    RxAck = 1'b0;
  endtask

  int t0;
  int rise;
  int ov0;
  int fe0;
  int ev0;

  initial begin
    Reset = 1'b0;
    idle(3);
    check("rst_data", {24'h0, RxData}, 32'h0);
    check("rst_ready", {31'h0, RxReady}, 32'h0);
    check("rst_fe", {31'h0, FrameError}, 32'h0);
    check("rst_ov", {31'h0, Overrun}, 32'h0);
    check("rst_busy", {31'h0, Busy}, 32'h0);
    Reset = 1'b1;
    idle(5);

    // 1: single frame, latency
    t0   = cyc;
    rise = -1;
    q.push_back('{d: 8'h55, ov: 1'b0});
    fork
      send(8'h55, 1'b1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge Clock);
          if (RxReady) begin
            rise = cyc - t0;
            break;
          end
        end
      end
    join
    check("t1_latency", rise, 155);
    check("t1_fe", fe_cnt, 0);
    check("t1_ov", ov_cnt, 0);
    ack();
    check("t1_ack_clears", {31'h0, RxReady}, 32'h0);
    idle(3);

    // 2: back-to-back overrun
    ov0 = ov_cnt;
    q.push_back('{d: 8'hA3, ov: 1'b0});
    q.push_back('{d: 8'h0F, ov: 1'b1});
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b1);
    idle(2);
    check("t2_ov_pulses", ov_cnt - ov0, 1);
    check("t2_data", {24'h0, RxData}, 32'h0F);
    check("t2_ready", {31'h0, RxReady}, 32'h1);
    ack();
    idle(2);

    // 3: framing error, line stuck low
    fe0 = fe_cnt;
    ev0 = rdy_evt;
    send(8'hC4, 1'b0);
    idle(40);
    check("t3_fe_pulses", fe_cnt - fe0, 1);
    check("t3_data_held", {24'h0, RxData}, 32'h0F);
    check("t3_busy_low", {31'h0, Busy}, 32'h1);
    check("t3_no_ready", {31'h0, RxReady}, 32'h0);
    RxIn = 1'b1;
    idle(6);
    check("t3_busy_done", {31'h0, Busy}, 32'h0);
    check("t3_fe_total", fe_cnt - fe0, 1);
    check("t3_no_evt", rdy_evt - ev0, 0);

    // 4: short glitch
    fe0  = fe_cnt;
    ov0  = ov_cnt;
    ev0  = rdy_evt;
    RxIn = 1'b0;
    idle(5);
    RxIn = 1'b1;
    check("t4_busy_start", {31'h0, Busy}, 32'h1);
    idle(10);
    check("t4_busy_idle", {31'h0, Busy}, 32'h0);
    idle(10);
    check("t4_no_evt", rdy_evt - ev0, 0);
    check("t4_no_fe", fe_cnt - fe0, 0);
    check("t4_no_ov", ov_cnt - ov0, 0);

    // 5: ack coincides with second load
    ov0 = ov_cnt;
    q.push_back('{d: 8'h11, ov: 1'b0});
    q.push_back('{d: 8'h7E, ov: 1'b0});
    fork
      begin
        send(8'h11, 1'b1);
        send(8'h7E, 1'b1);
      end
      begin
        repeat (314) @(posedge Clock);
        #1 RxAck = 1'b1;
        @(posedge Clock);
        #1 RxAck = 1'b0;
      end
    join
    check("t5_ready", {31'h0, RxReady}, 32'h1);
    check("t5_data", {24'h0, RxData}, 32'h7E);
    check("t5_no_ov", ov_cnt - ov0, 0);
    ack();
    check("t5_ack_clears", {31'h0, RxReady}, 32'h0);
    idle(3);

    // 6: reset mid-frame, then recover
    fork
      send(8'hFF, 1'b1);
      begin
        idle(60);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        check("t6_data", {24'h0, RxData}, 32'h0);
        check("t6_ready", {31'h0, RxReady}, 32'h0);
        check("t6_fe", {31'h0, FrameError}, 32'h0);
        check("t6_ov", {31'h0, Overrun}, 32'h0);
        check("t6_busy", {31'h0, Busy}, 32'h0);
        Reset = 1'b1;
      end
    join
    idle(5);
    q.push_back('{d: 8'h81, ov: 1'b0});
    send(8'h81, 1'b1);
    idle(5);
    check("t6_rx_data", {24'h0, RxData}, 32'h81);
    check("t6_rx_ready", {31'h0, RxReady}, 32'h1);
    check("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
